memoria_ram_wbuf: RTL and testbench

- Backing-store stage directly downstream of the L1 cache.
- Holds a 256x8 direct-mapped RAM with configurable access latency.
- Accepts dirty-line evictions from L1 into a small coalescing write buffer and drains them to RAM in the background.
- Services L1 miss fills, forwarding from the write buffer when the requested address is still pending there.

---
 rtl/memoria_ram_wbuf.sv | 148 ++++++++++++++
 tb/tb_memoria_ram_wbuf.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_ram_wbuf.sv
// memoria_ram_wbuf: backing RAM behind L1 with a coalescing eviction buffer, background drain and fill forwarding
module memoria_ram_wbuf #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int WB_DEPTH = 2,
  parameter int RAM_LAT  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  output logic [2:0]        wb_count,
  output logic              busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW = RAM_LAT > 1 ? $clog2(RAM_LAT) : 1;
  localparam logic [CW-1:0] LAT1 = CW'(RAM_LAT - 1);
  typedef enum logic [1:0] {IDLE, FWD, RD_WAIT, DRAIN} state_t;
  function automatic logic [DEPTH-1:0][DATA_W-1:0] mem_init();
    logic [DEPTH-1:0][DATA_W-1:0] m;
    for (int a = 0; a < DEPTH; a++) m[a] = DATA_W'(a);
    return m;
  endfunction
  logic [DEPTH-1:0][DATA_W-1:0] mem_q = mem_init();
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] hold_q, hold_d, rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] addr_q [WB_DEPTH];
  logic [ADDR_W-1:0] addr_d [WB_DEPTH];
  logic [DATA_W-1:0] data_q [WB_DEPTH];
  logic [DATA_W-1:0] data_d [WB_DEPTH];
  logic [2:0] count_q, count_d, wb_idx, tail;
  logic rd_hit, wb_hit, pop, wr_en;
  logic [DATA_W-1:0] rd_hit_data;
  // The draining head is excluded from coalescing so its committed data cannot change mid-flight.
  always_comb begin
    rd_hit = 1'b0;
    rd_hit_data = '0;
    wb_hit = 1'b0;
    wb_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (3'(i) < count_q && addr_q[i] == rd_addr) begin
        rd_hit = 1'b1;
        rd_hit_data = data_q[i];
      end
      if (3'(i) < count_q && addr_q[i] == wb_addr && !(state_q == DRAIN && i == 0)) begin
        wb_hit = 1'b1;
        wb_idx = 3'(i);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    raddr_d = raddr_q;
    hold_d = hold_q;
    rd_valid_d = 1'b0;
    rd_data_d = rd_data_q;
    pop = 1'b0;
    case (state_q)
      IDLE:
        if (rd_req) begin
          state_d = rd_hit ? FWD : RD_WAIT;
          hold_d = rd_hit_data;
          raddr_d = rd_addr;
          cnt_d = LAT1;
        end else if (count_q != 3'd0) begin
          state_d = DRAIN;
          cnt_d = LAT1;
        end
      FWD: begin
        rd_valid_d = 1'b1;
        rd_data_d = hold_q;
        state_d = IDLE;
      end
      RD_WAIT:
        if (cnt_q == '0) begin
          rd_valid_d = 1'b1;
          rd_data_d = mem_q[raddr_q];
          state_d = IDLE;
        end else cnt_d = cnt_q - 1'b1;
      DRAIN:
        if (cnt_q == '0) begin
          pop = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // Pop shifts the FIFO down first; coalesce/append indices are then rebased onto the shifted slots.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wr_en = wb_req && wb_ready;
    tail = count_q - {2'b0, pop};
    count_d = tail + {2'b0, wr_en && !wb_hit};
    if (pop) for (int i = 0; i < WB_DEPTH - 1; i++) begin
      addr_d[i] = addr_q[i+1];
      data_d[i] = data_q[i+1];
    end
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (wr_en && wb_hit && 3'(i) + {2'b0, pop} == wb_idx) data_d[i] = wb_data;
      if (wr_en && !wb_hit && 3'(i) == tail) begin
        addr_d[i] = wb_addr;
        data_d[i] = wb_data;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      raddr_q <= '0;
      hold_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      raddr_q <= raddr_d;
      hold_q <= hold_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      count_q <= count_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  always_ff @(posedge clock) begin
    if (reset && pop) mem_q[addr_q[0]] <= data_q[0];
  end
  assign wb_ready = count_q < 3'(WB_DEPTH) || wb_hit;
  assign rd_ready = state_q == IDLE;
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign wb_count = count_q;
  assign busy = state_q != IDLE || count_q != 3'd0;
endmodule

// File: tb/tb_memoria_ram_wbuf.sv
// tb_memoria_ram_wbuf: directed test-plan steps plus random traffic against a queue/array reference model
module tb_memoria_ram_wbuf;
  localparam int LAT = 3;
  localparam int WD = 2;
  logic clock = 1'b0, reset = 1'b0, rd_req = 1'b0, wb_req = 1'b0;
  logic [7:0] rd_addr = '0, wb_addr = '0, wb_data = '0;
  logic rd_ready, rd_valid, wb_ready, busy;
  logic [7:0] rd_data;
  logic [2:0] wb_count;
  int errors = 0, checks = 0;
  logic [15:0] q[$];
  logic [7:0] mm [256];
  int mode = 0, cyc = 0, done_at = 0;
  logic [7:0] m_addr = '0, m_hold = '0, m_data = '0;
  logic m_valid = 1'b0;

  memoria_ram_wbuf #(.ADDR_W(8), .DATA_W(8), .WB_DEPTH(WD), .RAM_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready), .wb_count(wb_count),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  // Model modes: 0 idle, 1 forwarding, 2 RAM read, 3 draining head.
  function automatic int wb_hit();
    for (int i = 0; i < q.size(); i++)
      if (!(mode == 3 && i == 0) && q[i][15:8] == wb_addr) return i;
    return -1;
  endfunction

  function automatic int rd_hit();
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i][15:8] == rd_addr) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    #1;
    chk("rd_ready", 32'(rd_ready), 32'(mode == 0));
    chk("wb_ready", 32'(wb_ready), 32'(q.size() < WD || wb_hit() >= 0));
    chk("wb_count", 32'(wb_count), 32'(q.size()));
    chk("busy", 32'(busy), 32'(mode != 0 || q.size() != 0));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_data", 32'(rd_data), 32'(m_data));
  endtask

  task automatic model_edge();
    int wi, ri;
    bit pop, wr_ok;
    cyc++;
    if (!reset) begin
      q.delete();
      mode = 0;
      m_valid = 1'b0;
      m_data = '0;
      return;
    end
    wi = wb_hit();
    wr_ok = wb_req && (q.size() < WD || wi >= 0);
    pop = 1'b0;
    m_valid = 1'b0;
    case (mode)
      0:
        if (rd_req) begin
          ri = rd_hit();
          if (ri >= 0) begin
            mode = 1;
            m_hold = q[ri][7:0];
            done_at = cyc + 1;
          end else begin
            mode = 2;
            m_addr = rd_addr;
            done_at = cyc + LAT;
          end
        end else if (q.size() > 0) begin
          mode = 3;
          done_at = cyc + LAT;
        end
      1, 2:
        if (cyc == done_at) begin
          m_valid = 1'b1;
          m_data = (mode == 1) ? m_hold : mm[m_addr];
          mode = 0;
        end
      default:
        if (cyc == done_at) begin
          mm[q[0][15:8]] = q[0][7:0];
          pop = 1'b1;
          mode = 0;
        end
    endcase
    if (wr_ok) begin
      if (wi >= 0) q[wi] = {q[wi][15:8], wb_data};
      else q.push_back({wb_addr, wb_data});
    end
    if (pop) void'(q.pop_front());
  endtask

  task automatic step(input bit c = 1'b1);
    if (c) check_out();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    rd_req = 1'b0;
    wb_req = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wb_addr = a;
    wb_data = d;
    wb_req = 1'b1;
    step();
    wb_req = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mm[a] = 8'(a);
    @(negedge clock);
    step(1'b0);
    step(1'b0);
    reset = 1'b1;
    #1;
    chk("rst_rd_ready", 32'(rd_ready), 32'd1);
    chk("rst_wb_ready", 32'(wb_ready), 32'd1);
    chk("rst_wb_count", 32'(wb_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // RAM read latency
    rd_addr = 8'h10;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t1_rd_ready_low", 32'(rd_ready), 32'd0);
      chk("t1_no_valid_yet", 32'(rd_valid), 32'd0);
      step();
    end
    #1;
    chk("t1_valid", 32'(rd_valid), 32'd1);
    chk("t1_data", 32'(rd_data), 32'h10);
    idle(1);

    // Forward from the buffer before drain
    wr(8'h04, 8'hA5);
    rd_addr = 8'h04;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    #1;
    chk("t2_not_yet", 32'(rd_valid), 32'd0);
    step();
    #1;
    chk("t2_fwd_valid", 32'(rd_valid), 32'd1);
    chk("t2_fwd_data", 32'(rd_data), 32'hA5);
    chk("t2_mem_old", 32'(dut.mem_q[4]), 32'h04);
    idle(6);
    chk("t2_mem_new", 32'(dut.mem_q[4]), 32'hA5);

    // Coalescing
    wr(8'h05, 8'h11);
    wr(8'h05, 8'h22);
    #1;
    chk("t3_coalesced_count", 32'(wb_count), 32'd1);
    idle(5);
    chk("t3_drained_count", 32'(wb_count), 32'd0);
    chk("t3_mem", 32'(dut.mem_q[5]), 32'h22);

    // Full buffer, head locked while draining, FIFO drain order
    wr(8'h01, 8'hAA);
    wr(8'h02, 8'hBB);
    wb_addr = 8'h03;
    #1;
    chk("t4_full_new_addr", 32'(wb_ready), 32'd0);
    wb_addr = 8'h02;
    #1;
    chk("t4_full_match", 32'(wb_ready), 32'd1);
    wb_addr = 8'h01;
    #1;
    chk("t4_head_locked", 32'(wb_ready), 32'd0);
    step();
    step();
    #1;
    chk("t4_mem1_pending", 32'(dut.mem_q[1]), 32'h01);
    step();
    #1;
    chk("t4_mem1_commit", 32'(dut.mem_q[1]), 32'hAA);
    chk("t4_mem2_pending", 32'(dut.mem_q[2]), 32'h02);
    chk("t4_count_after_first", 32'(wb_count), 32'd1);
    step();
    step();
    step();
    #1;
    chk("t4_mem2_still_old", 32'(dut.mem_q[2]), 32'h02);
    step();
    #1;
    chk("t4_mem2_commit", 32'(dut.mem_q[2]), 32'hBB);
    chk("t4_empty", 32'(wb_count), 32'd0);

    // Read wins over a pending drain
    wr(8'h30, 8'h77);
    rd_addr = 8'h40;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    #1;
    chk("t5_read_first", 32'(rd_ready), 32'd0);
    chk("t5_buf_kept", 32'(wb_count), 32'd1);
    step();
    step();
    step();
    #1;
    chk("t5_valid", 32'(rd_valid), 32'd1);
    chk("t5_data", 32'(rd_data), 32'h40);
    chk("t5_mem_not_yet", 32'(dut.mem_q[8'h30]), 32'h30);
    step();
    #1;
    chk("t5_drain_after", 32'(rd_ready), 32'd0);
    idle(4);
    chk("t5_mem_commit", 32'(dut.mem_q[8'h30]), 32'h77);

    // Reset one cycle into a drain discards the entry
    wr(8'h07, 8'h99);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("t6_mem_kept", 32'(dut.mem_q[7]), 32'h07);
    chk("t6_count", 32'(wb_count), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_no_valid", 32'(rd_valid), 32'd0);
    idle(5);
    chk("t6_mem_after", 32'(dut.mem_q[7]), 32'h07);

    // Random traffic on a small address window to provoke hits and coalescing
    repeat (600) begin
      rd_req = ($urandom_range(0, 3) == 0);
      rd_addr = 8'($urandom_range(0, 7));
      wb_req = ($urandom_range(0, 2) == 0);
      wb_addr = 8'($urandom_range(0, 7));
      wb_data = 8'($urandom);
      reset = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1;
    idle(20);
    for (int a = 0; a < 8; a++) chk("rand_mem", 32'(dut.mem_q[a]), 32'(mm[a]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
